// File: rtl/ffp_buzzer_lockout_if.sv
// Button/host/winner signal bundle for the fastest-finger-first front end.
// The master side is the host/test environment; the slave side is ffp_buzzer_lockout.
interface ffp_buzzer_lockout_if;
  logic [3:0] btn_raw;
  logic       arm;
  logic       host_clear;
  logic [3:0] player;
  logic       winner_valid;
  logic       armed;
  logic [3:0] foul;

  modport master (
    output btn_raw, arm, host_clear,
    input  player, winner_valid, armed, foul
  );

  modport slave (
    input  btn_raw, arm, host_clear,
    output player, winner_valid, armed, foul
  );
endinterface

// File: rtl/ffp_buzzer_lockout.sv
// Fastest-finger-first front end: 2-FF sync, per-button debounce, first-press lockout.
// Define FFP_FALSE_START_EN to track IDLE presses as fouls that bar a player from winning.
module ffp_buzzer_lockout #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ffp_buzzer_lockout_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       db;
  logic [3:0]       db_prev;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       press;
  logic [3:0]       eligible;
  logic [3:0]       first;
  state_t           state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn_raw;
      s2 <= s1;
    end
  end

  // A level only changes after s2 has disagreed with it for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      db_prev <= db;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = db & ~db_prev;

`ifdef FFP_FALSE_START_EN
  logic [3:0] foul_q;
  assign eligible = press & ~foul_q;
  assign bus.foul = foul_q;
`else
  assign eligible = press;
  assign bus.foul = 4'b0000;
`endif

  // Isolate the lowest set bit so simultaneous presses resolve to the lowest index.
  assign first = eligible & (~eligible + 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bus.player       <= '0;
      bus.winner_valid <= 1'b0;
      bus.armed        <= 1'b0;
`ifdef FFP_FALSE_START_EN
      foul_q           <= '0;
`endif
    end else if (bus.host_clear) begin
      state            <= IDLE;
      bus.player       <= '0;
      bus.winner_valid <= 1'b0;
      bus.armed        <= 1'b0;
`ifdef FFP_FALSE_START_EN
      foul_q           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef FFP_FALSE_START_EN
          foul_q <= foul_q | press;
`endif
          if (bus.arm) begin
            state     <= ARMED;
            bus.armed <= 1'b1;
          end
        end
        ARMED: begin
          if (|eligible) begin
            state            <= LOCKED;
            bus.player       <= first;
            bus.winner_valid <= 1'b1;
            bus.armed        <= 1'b0;
          end
        end
        LOCKED: begin
        end
        default: begin
          state            <= IDLE;
          bus.player       <= '0;
          bus.winner_valid <= 1'b0;
          bus.armed        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ffp_buzzer_lockout.md
Name: ffp_buzzer_lockout

Overview:
- Front-end stage of the fastest-finger-first quiz.
- Takes the four raw player push-buttons, then synchronises and debounces each one.
- Once the host arms a question, it latches the first valid press and locks out all other players.
- Drives a 4-bit one-hot `player` vector (0000 = no winner) directly into the 7-segment winner-display decoder, which accepts only 0000 or one-hot codes.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles (after sync) required before a debounced level changes; legal range 2..65535.
- CNT_W, 16: width of each per-button debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_raw  input  4  raw player buttons, asynchronous, active-high; bit i = player i+1.
- arm  input  1  host pulse (sync to clk): open a question.
- host_clear  input  1  host pulse (sync to clk): end question, clear winner.
- player  output  4  one-hot winner, 0000 when none; feeds display stage.
- winner_valid  output  1  high while a winner is latched (== |player).
- armed  output  1  high in ARMED state.
- foul  output  4  per-player false-start flags (see Optional Feature).

Behaviour:
- Reset (async, `rst`=1): state=IDLE; `player`=0000, `winner_valid`=0, `armed`=0, `foul`=0000; sync flops, debounced levels and counters all 0. Release is synchronous to the next `clk` edge.
- Synchroniser: 2-FF per button. Sync output s2[i] reflects `btn_raw` sampled two edges earlier.
- Debounce, per button:
  - counter clears whenever s2[i]==db[i];
  - otherwise it increments;
  - when the counter == DEBOUNCE_CYCLES-1 and s2[i]!=db[i], db[i] takes s2[i] and the counter clears.
  - Applies identically to press and release.
- Press event: rising edge of db[i] (db[i]=1, previous db[i]=0), one cycle wide.
- Latency: `btn_raw`[i] high and stable from before edge k -> `player` updates at edge k+DEBOUNCE_CYCLES+2 (2 sync, DEBOUNCE_CYCLES debounce, 0 extra for capture; capture is registered in the same edge the event is computed from the db register). Fixed and exact; the bench checks it.
- FSM:
  - IDLE: `arm`=1 -> ARMED. Press events are ignored (but see Optional Feature).
  - ARMED: the first cycle with any eligible press event -> LOCKED, with `player` = that event vector reduced to one-hot.
  - LOCKED: hold `player`. All further events are ignored. `arm` is ignored.
  - `host_clear`=1 in any state -> IDLE next edge; `player`=0000, `foul`=0000.
- Eligible event: press event on bit i with foul[i]=0.
- Tie-break: simultaneous eligible events in the same cycle -> lowest index wins (bit0 > bit1 > bit2 > bit3). `player` is never multi-hot.
- Button already held when `arm` arrives: no event is generated; the player must release (debounced) and re-press.
- `arm` and press event on the same edge: the event is not counted (ARMED takes effect after that edge).
- `arm` and `host_clear` on the same edge: `host_clear` wins -> IDLE.
- `arm` in ARMED or LOCKED: no effect.
- Debounce/sync state is not cleared by `host_clear`, only by `rst`.
- `rst` mid-question: immediate return to reset values; no winner survives.
- `winner_valid` = OR of `player`. `armed` = (state==ARMED).

Optional Feature:
- Macro: FFP_FALSE_START_EN.
- Defined: a press event on bit i while in IDLE sets foul[i]=1. A fouled player cannot win until `host_clear` or `rst`. Foul flags persist through ARMED/LOCKED. If all four players are fouled, ARMED waits indefinitely until `host_clear`.
- Undefined: IDLE presses are simply ignored; `foul` is tied to 0000 and no foul registers exist.

Test Plan:
- Reset: assert `rst` mid-LOCKED with `player`=0100 -> `player`=0000, `winner_valid`=0, `armed`=0 asynchronously; IDLE after release.
- Single press, DEBOUNCE_CYCLES=4: `arm`, then `btn_raw`=0010 stable from before edge k -> `player`=0010 exactly at edge k+6, `winner_valid`=1; later `btn_raw`=1000 -> `player` stays 0010.
- Bounce: `btn_raw`[0] toggles every 2 cycles for 20 cycles then stays high, DEBOUNCE_CYCLES=4 -> no event during bouncing; `player`=0001 exactly 6 edges after the last toggle.
- Tie and hold: `btn_raw`=1100 simultaneous -> `player`=0100; button 3 held across `arm` -> no win until released and re-pressed.
- Control races: `arm` and `host_clear` same edge -> stays IDLE; `host_clear` in LOCKED -> `player`=0000 next edge; `arm` and press same edge -> press ignored.
- FFP_FALSE_START_EN: press player 1 in IDLE -> `foul`=0001; `arm`, player 1 then player 2 press -> `player`=0010; `host_clear` -> `foul`=0000.
